// File: rtl/max_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : max_pkg
// Description : Shared types, mode constants and helpers for the max_n
//               temporal max/min gate.
// Revision    : 1.0 - initial release
// ============================================================================
package max_pkg;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        WAIT  = 2'd1,
        FIRE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    // Widest channel vector the priority helper accepts.
    localparam int LSB_W = 32;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int unsigned lsb_index(input logic [LSB_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = LSB_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/max_n_if.sv
`default_nettype none
// ============================================================================
// Module      : max_n_if
// Description : Channel/result bundle of the max_n gate. t_win exists only
//               when MAX_TIMESTAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface max_n_if #(
    parameter int N_IN = 4
`ifdef MAX_TIMESTAMP_EN
    ,
    parameter int GAMMA_CYCLE_WIDTH = 16
`endif
);
    localparam int IDX_W = $clog2(N_IN);

    logic             mode;
    logic [N_IN-1:0]  ch_en;
    logic [N_IN-1:0]  a;
    logic             y;
    logic             y_valid;
    logic [IDX_W-1:0] win_idx;
`ifdef MAX_TIMESTAMP_EN
    logic [GAMMA_CYCLE_WIDTH-1:0] t_win;
`endif

    modport master (
        output mode, ch_en, a,
        input  y, y_valid, win_idx
`ifdef MAX_TIMESTAMP_EN
        , input t_win
`endif
    );

    modport slave (
        input  mode, ch_en, a,
        output y, y_valid, win_idx
`ifdef MAX_TIMESTAMP_EN
        , output t_win
`endif
    );

endinterface
`default_nettype wire

// File: rtl/max_n_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : max_pulse_gen
// Description : Regenerates a registered PULSE_WIDTH-cycle pulse per trigger.
// Revision    : 1.0 - initial release
// ============================================================================
module max_pulse_gen #(
    parameter int PULSE_WIDTH = 8
) (
    input  wire logic aclk,
    input  wire logic grst_n,
    input  wire logic rst,
    input  wire logic i_trigger,
    output logic      o_y,
    output logic      o_last
);
    localparam int CNT_W = $clog2(PULSE_WIDTH + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_y;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_trigger) begin
            w_cnt_nxt = CNT_W'(PULSE_WIDTH);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // y is registered from the next count so the output pulse is glitch-free.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            r_cnt <= '0;
            r_y   <= 1'b0;
        end else if (rst) begin
            r_cnt <= '0;
            r_y   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_y   <= (w_cnt_nxt != '0);
        end
    end

    assign o_y    = r_y;
    assign o_last = (r_cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/max_n.sv
`default_nettype none
// ============================================================================
// Module      : max_n
// Description : N-input temporal max/min gate with pulse regeneration.
//               Define MAX_TIMESTAMP_EN to add the gamma counter and t_win.
// Revision    : 1.0 - initial release
// ============================================================================
module max_n
    import max_pkg::*;
#(
    parameter int N_IN              = 4,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8
) (
    input  wire logic aclk,
    input  wire logic grst_n,
    input  wire logic rst,
    max_n_if.slave    bus
);
    localparam int IDX_W = $clog2(N_IN);

    if (N_IN < 2 || N_IN > LSB_W || PULSE_WIDTH < 1 || GAMMA_CYCLE_WIDTH < 1) begin : g_param_check
        $error("max_n: parameter out of range");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_mode;
    logic [N_IN-1:0]  r_ch_en;
    logic [N_IN-1:0]  r_prev_a;
    logic [N_IN-1:0]  r_arr;
    logic [N_IN-1:0]  w_rise;
    logic             w_any_rise;
    logic             w_all_arrived;
    logic             w_decide;
    logic             w_fire;
    logic             w_pulse_last;
    logic             w_y;
    logic             r_y_valid;
    logic [IDX_W-1:0] r_win_idx;
    logic [IDX_W-1:0] w_win_idx;

    // Disabled channels never rise but count as already arrived.
    assign w_rise        = bus.a & ~r_prev_a & r_ch_en;
    assign w_any_rise    = |w_rise;
    assign w_all_arrived = &(r_arr | w_rise | ~r_ch_en);
    assign w_decide      = w_any_rise &
                           (w_all_arrived | (r_mode == MODE_MIN && r_state == ARMED));
    assign w_win_idx     = IDX_W'(lsb_index(LSB_W'(w_rise)));

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            r_state <= ARMED;
        end else if (rst) begin
            r_state <= ARMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARMED: begin
                if (w_decide) begin
                    w_state_nxt = FIRE;
                end else if (w_any_rise) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_decide) begin
                    w_state_nxt = FIRE;
                end
            end
            FIRE: begin
                if (w_pulse_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = ARMED;
        endcase
    end

    // A same-cycle rst discards the deciding edge.
    always_comb begin
        w_fire = 1'b0;
        case (r_state)
            ARMED, WAIT: w_fire = w_decide & ~rst;
            default:     w_fire = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            r_prev_a  <= '0;
            r_mode    <= MODE_MAX;
            r_ch_en   <= '0;
            r_arr     <= '0;
            r_y_valid <= 1'b0;
            r_win_idx <= '0;
        end else begin
            r_prev_a <= bus.a;
            if (rst) begin
                r_mode    <= bus.mode;
                r_ch_en   <= bus.ch_en;
                r_arr     <= '0;
                r_y_valid <= 1'b0;
                r_win_idx <= '0;
            end else begin
                if (r_state == ARMED || r_state == WAIT) begin
                    r_arr <= r_arr | w_rise;
                end
                if (w_fire) begin
                    r_y_valid <= 1'b1;
                    r_win_idx <= w_win_idx;
                end
            end
        end
    end

    max_pulse_gen #(
        .PULSE_WIDTH (PULSE_WIDTH)
    ) u_pulse_gen (
        .aclk      (aclk),
        .grst_n    (grst_n),
        .rst       (rst),
        .i_trigger (w_fire),
        .o_y       (w_y),
        .o_last    (w_pulse_last)
    );

    assign bus.y       = w_y;
    assign bus.y_valid = r_y_valid;
    assign bus.win_idx = r_win_idx;

`ifdef MAX_TIMESTAMP_EN
    logic [GAMMA_CYCLE_WIDTH-1:0] r_gamma;
    logic [GAMMA_CYCLE_WIDTH-1:0] r_t_win;

    // Gamma time saturates rather than wrapping so late edges stay ordered.
    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            r_gamma <= '0;
            r_t_win <= '0;
        end else if (rst) begin
            r_gamma <= '0;
            r_t_win <= '0;
        end else begin
            if (r_gamma != '1) begin
                r_gamma <= r_gamma + 1'b1;
            end
            if (w_fire) begin
                r_t_win <= r_gamma;
            end
        end
    end

    assign bus.t_win = r_t_win;
`endif

endmodule
`default_nettype wire

// File: tb/tb_max_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_n
// Description : Directed self-checking bench for max_n.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_n;
    import max_pkg::*;

    localparam int N_IN  = 4;
    localparam int PW    = 8;
    localparam int NEVER = 1000;

    logic aclk = 1'b0;
    logic grst_n;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   rise_t [4];
    int   dip_t  [4];
    logic [3:0] tog;

`ifdef MAX_TIMESTAMP_EN
    max_n_if #(.N_IN(N_IN), .GAMMA_CYCLE_WIDTH(16)) bus  ();
    max_n_if #(.N_IN(N_IN), .GAMMA_CYCLE_WIDTH(4))  bus4 ();
`else
    max_n_if #(.N_IN(N_IN)) bus ();
`endif

    max_n #(.N_IN(N_IN), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(PW)) u_dut (
        .aclk   (aclk),
        .grst_n (grst_n),
        .rst    (rst),
        .bus    (bus)
    );

`ifdef MAX_TIMESTAMP_EN
    max_n #(.N_IN(N_IN), .GAMMA_CYCLE_WIDTH(4), .PULSE_WIDTH(PW)) u_dut4 (
        .aclk   (aclk),
        .grst_n (grst_n),
        .rst    (rst),
        .bus    (bus4)
    );
    assign bus4.mode  = bus.mode;
    assign bus4.ch_en = bus.ch_en;
    assign bus4.a     = bus.a;
`endif

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_rst(input logic m, input logic [3:0] en, input logic [3:0] av);
        bus.mode  = m;
        bus.ch_en = en;
        bus.a     = av;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
    endtask

    // Gamma time t: check outputs, drive a for cycle t, then advance.
    task automatic run(input string tag, input int ncyc, input int ylo);
        logic [3:0] av;
        for (int t = 0; t < ncyc; t++) begin
            check({tag, "_y"},       {31'd0, bus.y},       {31'd0, (t >= ylo && t < ylo + PW)});
            check({tag, "_y_valid"}, {31'd0, bus.y_valid}, {31'd0, (t >= ylo)});
            for (int i = 0; i < 4; i++) begin
                av[i] = ((t >= rise_t[i]) && (t != dip_t[i])) || (tog[i] && t[0]);
            end
            bus.a = av;
            tick();
        end
    endtask

    task automatic set_sched(input int r0, input int r1, input int r2, input int r3,
                             input int d0, input int d1, input int d2, input int d3,
                             input logic [3:0] tg);
        rise_t = '{r0, r1, r2, r3};
        dip_t  = '{d0, d1, d2, d3};
        tog    = tg;
    endtask

    initial begin
        grst_n    = 1'b0;
        rst       = 1'b0;
        bus.mode  = 1'b0;
        bus.ch_en = '0;
        bus.a     = '0;
        #2;
        check("rst_y",       {31'd0, bus.y},       32'd0);
        check("rst_y_valid", {31'd0, bus.y_valid}, 32'd0);
        check("rst_win_idx", {30'd0, bus.win_idx}, 32'd0);
        check("rst_state",   {30'd0, u_dut.r_state}, {30'd0, ARMED});
`ifdef MAX_TIMESTAMP_EN
        check("rst_t_win",   {16'd0, bus.t_win},   32'd0);
`endif
        #10 grst_n = 1'b1;

        // Max, all enabled: last arrival ch3 at t=10.
        do_rst(MODE_MAX, 4'hF, 4'h0);
        set_sched(3, 7, 5, 10, NEVER, NEVER, NEVER, NEVER, 4'h0);
        run("max", 22, 11);
        check("max_win_idx", {30'd0, bus.win_idx}, 32'd3);
`ifdef MAX_TIMESTAMP_EN
        check("max_t_win", {16'd0, bus.t_win}, 32'd10);
`endif

        // Min, same stimulus: first arrival ch0 at t=3.
        do_rst(MODE_MIN, 4'hF, 4'h0);
        run("min", 14, 4);
        check("min_win_idx", {30'd0, bus.win_idx}, 32'd0);
        check("min_state",   {30'd0, u_dut.r_state}, {30'd0, DONE});
`ifdef MAX_TIMESTAMP_EN
        check("min_t_win", {16'd0, bus.t_win}, 32'd3);
`endif

        // Max with ch1/ch3 disabled and toggling.
        do_rst(MODE_MAX, 4'b0101, 4'h0);
        set_sched(2, NEVER, 6, NEVER, NEVER, NEVER, NEVER, NEVER, 4'b1010);
        run("max_en", 16, 7);
        check("max_en_win_idx", {30'd0, bus.win_idx}, 32'd2);
`ifdef MAX_TIMESTAMP_EN
        check("max_en_t_win", {16'd0, bus.t_win}, 32'd6);
`endif

        // Tie at t=9 on ch1/ch3; ch0 re-rises at t=12 during FIRE.
        do_rst(MODE_MAX, 4'hF, 4'h0);
        set_sched(2, 9, 5, 9, 11, NEVER, NEVER, NEVER, 4'h0);
        run("tie", 20, 10);
        check("tie_win_idx", {30'd0, bus.win_idx}, 32'd1);
`ifdef MAX_TIMESTAMP_EN
        check("tie_t_win", {16'd0, bus.t_win}, 32'd9);
`endif

        // No channels enabled: never fires.
        do_rst(MODE_MAX, 4'h0, 4'h0);
        set_sched(1, 2, 3, 4, NEVER, NEVER, NEVER, NEVER, 4'h0);
        run("no_en", 10, NEVER);
        check("no_en_state", {30'd0, u_dut.r_state}, {30'd0, ARMED});

        // rst during WAIT with a concurrent ch2 edge.
        do_rst(MODE_MAX, 4'hF, 4'h0);
        set_sched(1, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER, NEVER, 4'h0);
        run("pre_rst", 4, NEVER);
        check("pre_rst_state", {30'd0, u_dut.r_state}, {30'd0, WAIT});
        do_rst(MODE_MAX, 4'hF, 4'b0101);
        check("rst_wait_state",   {30'd0, u_dut.r_state}, {30'd0, ARMED});
        check("rst_wait_y_valid", {31'd0, bus.y_valid},   32'd0);
        set_sched(0, 2, 0, 5, 10, NEVER, 12, NEVER, 4'h0);
        run("post_rst", 23, 14);
        check("post_rst_win_idx", {30'd0, bus.win_idx}, 32'd2);
`ifdef MAX_TIMESTAMP_EN
        check("post_rst_t_win", {16'd0, bus.t_win}, 32'd13);
`endif

        // Late last arrival; then grst_n pulsed mid-FIRE.
        do_rst(MODE_MAX, 4'hF, 4'h0);
        set_sched(1, 2, 3, 20, NEVER, NEVER, NEVER, NEVER, 4'h0);
        run("sat", 23, 21);
        check("sat_y_high", {31'd0, bus.y}, 32'd1);
`ifdef MAX_TIMESTAMP_EN
        check("sat_t_win16", {16'd0, bus.t_win},  32'd20);
        check("sat_t_win4",  {28'd0, bus4.t_win}, 32'd15);
`endif
        #2 grst_n = 1'b0;
        #1;
        check("grst_y",       {31'd0, bus.y},       32'd0);
        check("grst_y_valid", {31'd0, bus.y_valid}, 32'd0);
        check("grst_win_idx", {30'd0, bus.win_idx}, 32'd0);
        check("grst_ch_en",   {28'd0, u_dut.r_ch_en}, 32'd0);
        check("grst_state",   {30'd0, u_dut.r_state}, {30'd0, ARMED});
        #2 grst_n = 1'b1;
        tick();
        check("post_grst_y", {31'd0, bus.y}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
